// File: rtl/gpio_cap_pkg.sv
// Shared types and constants for the GPIO edge-capture block.
package gpio_cap_pkg;

  // Field widths of the event record. The top-level WIDTH and TS_WIDTH
  // parameters default to these and must stay equal to them.
  localparam int CAP_WIDTH    = 32;
  localparam int CAP_TS_WIDTH = 16;

  // Dropped-event counter width and its saturation value.
  localparam int                    DROP_CNT_W   = 8;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = 8'd255;

  // One queued event: pin levels, pins whose enabled edge fired, and the
  // timestamp of the detect cycle.
  typedef struct packed {
    logic [CAP_WIDTH-1:0]    level;
    logic [CAP_WIDTH-1:0]    change;
    logic [CAP_TS_WIDTH-1:0] ts;
  } gpio_cap_evt_t;

endpackage

// File: rtl/gpio_cap_fifo.sv
// Synchronous event FIFO with a registered head. A record pushed into an
// empty FIFO becomes visible on the following cycle, never the same cycle.
// When full, a push is still accepted if a pop happens in the same cycle.
module gpio_cap_fifo
  import gpio_cap_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  gpio_cap_evt_t push_data_i,
  output logic          full_o,
  output logic          valid_o,
  input  logic          ready_i,
  output gpio_cap_evt_t data_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  gpio_cap_evt_t r_mem [DEPTH];
  gpio_cap_evt_t r_head;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic          w_empty;
  logic          w_pop;
  logic          w_wr;
  logic [AW-1:0] w_rd_next;

  assign w_empty   = (r_count == '0);
  assign full_o    = (r_count == CW'(DEPTH));
  assign valid_o   = !w_empty;
  assign w_pop     = valid_o && ready_i;
  assign w_wr      = push_i && (!full_o || w_pop);
  assign w_rd_next = r_rd_ptr + 1'b1;
  assign data_o    = r_head;

  // Storage write; contents need no reset because the count gates visibility.
  always_ff @(posedge clk_i) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= push_data_i;
    end
  end

  // Pointer and occupancy tracking; simultaneous push and pop keep the count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_next;
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Head register: reload from the next slot on pop, or capture the
  // incoming record when it becomes the only entry.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_head <= '0;
    end else if (w_pop) begin
      if (r_count == CW'(1)) begin
        if (w_wr) begin
          r_head <= push_data_i;
        end
      end else begin
        // With two or more entries the next slot is already written, and a
        // concurrent write can never target it.
        r_head <= r_mem[w_rd_next];
      end
    end else if (w_empty && w_wr) begin
      r_head <= push_data_i;
    end
  end

endmodule

// File: rtl/gpio_edge_capture.sv
// GPIO receive side: synchronises asynchronous pins, detects enabled
// rising/falling edges and queues one timestamped record per change cycle.
module gpio_edge_capture
  import gpio_cap_pkg::*;
#(
  parameter int WIDTH       = CAP_WIDTH,
  parameter int DEPTH       = 8,
  parameter int TS_WIDTH    = CAP_TS_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [WIDTH-1:0]      gpio_i,
  input  logic [WIDTH-1:0]      rise_en_i,
  input  logic [WIDTH-1:0]      fall_en_i,
  output logic [WIDTH-1:0]      level_o,
  output logic                  evt_valid_o,
  input  logic                  evt_ready_i,
  output logic [WIDTH-1:0]      evt_level_o,
  output logic [WIDTH-1:0]      evt_change_o,
  output logic [TS_WIDTH-1:0]   evt_ts_o,
  input  logic                  ovf_clr_i,
  output logic                  overflow_o,
  output logic [DROP_CNT_W-1:0] drop_cnt_o
);

  localparam int WARM_W = $clog2(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0]      r_prev;
  logic [WARM_W-1:0]     r_warm;
  logic                  r_primed;
  logic [TS_WIDTH-1:0]   r_ts;
  logic                  r_overflow;
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  logic [WIDTH-1:0] w_change;
  logic             w_push;
  logic             w_full;
  logic             w_drop;
  gpio_cap_evt_t    w_rec;
  gpio_cap_evt_t    w_head;

  // Synchroniser chain; the last stage is the usable pin level.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= gpio_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign level_o = r_sync[SYNC_STAGES-1];

  // Previous level, loaded every cycle regardless of the enables.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_prev <= '0;
    end else begin
      r_prev <= level_o;
    end
  end

  // Arming: events are suppressed until the synchroniser has filled with
  // real pin samples and prev has captured one, so pins held high through
  // reset do not look like rising edges.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_warm   <= '0;
      r_primed <= 1'b0;
    end else if (!r_primed) begin
      if (r_warm == WARM_W'(SYNC_STAGES)) begin
        r_primed <= 1'b1;
      end else begin
        r_warm <= r_warm + 1'b1;
      end
    end
  end

  // Free-running timestamp, wraps naturally at its width.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ts <= '0;
    end else begin
      r_ts <= r_ts + 1'b1;
    end
  end

  assign w_change = ((level_o & ~r_prev) & rise_en_i)
                  | ((~level_o & r_prev) & fall_en_i);
  assign w_push   = r_primed && (|w_change);
  assign w_rec    = '{level: level_o, change: w_change, ts: r_ts};

  // A push is lost only when the FIFO is full and nothing leaves this cycle.
  assign w_drop = w_push && w_full && !(evt_valid_o && evt_ready_i);

  // Overflow flag and saturating drop counter; a drop in the clear cycle wins.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (ovf_clr_i) begin
      r_overflow <= w_drop;
      r_drop_cnt <= w_drop ? DROP_CNT_W'(1) : '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_cnt != DROP_CNT_MAX) begin
        r_drop_cnt <= r_drop_cnt + 1'b1;
      end
    end
  end

  assign overflow_o = r_overflow;
  assign drop_cnt_o = r_drop_cnt;

  gpio_cap_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (w_push),
    .push_data_i (w_rec),
    .full_o      (w_full),
    .valid_o     (evt_valid_o),
    .ready_i     (evt_ready_i),
    .data_o      (w_head)
  );

  assign evt_level_o  = w_head.level;
  assign evt_change_o = w_head.change;
  assign evt_ts_o     = w_head.ts;

endmodule

// File: tb/tb_gpio_edge_capture.sv
// Directed bench for gpio_edge_capture: reset behaviour, edge detection,
// FIFO ordering, overflow handling and timestamp wrap.
module tb_gpio_edge_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] gpio, rise_en, fall_en;
  logic [31:0] level, evt_level, evt_change;
  logic        evt_valid, evt_ready, ovf_clr, overflow;
  logic [15:0] evt_ts;
  logic [7:0]  drop_cnt;

  // Bench model of the free-running timestamp.
  logic [15:0] m_ts;

  int n_vec = 0;
  int n_bad = 0;

  logic [15:0] exp_ts;
  logic [15:0] ts0;
  int          guard;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) m_ts <= '0;
    else     m_ts <= m_ts + 16'd1;
  end

  gpio_edge_capture dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .gpio_i       (gpio),
    .rise_en_i    (rise_en),
    .fall_en_i    (fall_en),
    .level_o      (level),
    .evt_valid_o  (evt_valid),
    .evt_ready_i  (evt_ready),
    .evt_level_o  (evt_level),
    .evt_change_o (evt_change),
    .evt_ts_o     (evt_ts),
    .ovf_clr_i    (ovf_clr),
    .overflow_o   (overflow),
    .drop_cnt_o   (drop_cnt)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("  ok   %s = %0h", tag, obs);
    end
  endtask

  // Advance one clock and land just after the edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pop_one();
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; gpio = 32'hFFFF_FFFF; rise_en = '1; fall_en = '1;
    evt_ready = 1'b0; ovf_clr = 1'b0;

    // 1. Pins high through reset: everything zero, then level without event
    tick(2);
    check_val("rst_level",    level, 0);
    check_val("rst_valid",    evt_valid, 0);
    check_val("rst_overflow", overflow, 0);
    check_val("rst_drop",     drop_cnt, 0);
    check_val("rst_change",   evt_change, 0);
    check_val("rst_ts",       evt_ts, 0);
    rst = 1'b0;
    tick();
    check_val("level_1cyc", level, 0);
    tick();
    check_val("level_2cyc", level, 32'hFFFF_FFFF);
    tick(6);
    check_val("no_evt_after_rst", evt_valid, 0);

    // 2. Single rising edge on pin 3, with latency and timestamp
    rise_en = '0; fall_en = '0; gpio = '0;
    tick(4);
    check_val("en_off_no_evt", evt_valid, 0);
    rise_en = 32'h8; gpio = 32'h8;
    tick(2);
    exp_ts = m_ts;
    check_val("rise_lat_early", evt_valid, 0);
    tick();
    check_val("rise_valid",  evt_valid, 1);
    check_val("rise_change", evt_change, 32'h8);
    check_val("rise_level",  evt_level, 32'h8);
    check_val("rise_ts",     evt_ts, exp_ts);
    pop_one();
    check_val("rise_popped", evt_valid, 0);

    // 3. Two pins fall together -> one record; rise-only ignores a fall
    rise_en = '0; fall_en = '0; gpio = 32'h29;
    tick(4);
    fall_en = 32'h21; gpio = 32'h08;
    tick(2);
    exp_ts = m_ts;
    tick();
    check_val("fall_valid",  evt_valid, 1);
    check_val("fall_change", evt_change, 32'h21);
    check_val("fall_level",  evt_level, 32'h08);
    check_val("fall_ts",     evt_ts, exp_ts);
    pop_one();
    check_val("fall_single", evt_valid, 0);
    rise_en = '1; fall_en = '0; gpio = '0;
    tick(4);
    check_val("rise_only_no_fall", evt_valid, 0);

    // 4. Ten toggles into an 8-deep FIFO -> 8 kept in order, 2 dropped
    rise_en = '1; fall_en = '1;
    for (int i = 0; i < 10; i++) begin
      gpio[0] = ~gpio[0];
      tick();
      if (i == 1) ts0 = m_ts;
    end
    tick(3);
    check_val("ovf_set",  overflow, 1);
    check_val("drop_two", drop_cnt, 2);
    evt_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check_val($sformatf("ord%0d_level", k), evt_level, (k % 2 == 0) ? 1 : 0);
      check_val($sformatf("ord%0d_ts", k), evt_ts, ts0 + 16'(k));
      tick();
    end
    evt_ready = 1'b0;
    check_val("drained", evt_valid, 0);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    check_val("clr_ovf",  overflow, 0);
    check_val("clr_drop", drop_cnt, 0);
    for (int i = 0; i < 308; i++) begin
      gpio[0] = ~gpio[0];
      tick();
      if (i == 1) ts0 = m_ts;
    end
    tick(3);
    check_val("drop_sat", drop_cnt, 255);
    check_val("ovf_sat",  overflow, 1);

    // 5. Full FIFO with simultaneous push and pop: accepted, no drop
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    check_val("clr_before_pp", drop_cnt, 0);
    gpio[0] = ~gpio[0];
    tick(2);
    exp_ts = m_ts;
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    check_val("pp_no_ovf",  overflow, 0);
    check_val("pp_no_drop", drop_cnt, 0);
    evt_ready = 1'b1;
    for (int k = 1; k < 8; k++) begin
      check_val($sformatf("pp%0d_ts", k), evt_ts, ts0 + 16'(k));
      check_val($sformatf("pp%0d_level", k), evt_level, (k % 2 == 0) ? 1 : 0);
      tick();
    end
    check_val("pp_last_ts",    evt_ts, exp_ts);
    check_val("pp_last_level", evt_level, 1);
    tick();
    evt_ready = 1'b0;
    check_val("pp_count8", evt_valid, 0);

    // Clear coincident with a drop
    for (int i = 0; i < 11; i++) begin
      gpio[0] = ~gpio[0];
      tick();
    end
    tick(3);
    check_val("drop_three", drop_cnt, 3);
    gpio[0] = ~gpio[0];
    tick(2);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check_val("clr_drop_cnt", drop_cnt, 1);
    check_val("clr_drop_ovf", overflow, 1);

    // 6. Reset with a full FIFO, then timestamp wrap
    rst = 1'b1; gpio = '0;
    tick();
    check_val("midrst_valid", evt_valid, 0);
    check_val("midrst_ovf",   overflow, 0);
    rst = 1'b0;
    guard = 0;
    while (m_ts != 16'hFFFD && guard < 70000) begin
      tick();
      guard++;
    end
    check_val("wrap_wait_bound", m_ts, 16'hFFFD);
    for (int i = 0; i < 4; i++) begin
      gpio[0] = ~gpio[0];
      tick();
    end
    tick(2);
    check_val("wrap_valid", evt_valid, 1);
    check_val("wrap_ffff",  evt_ts, 16'hFFFF);
    pop_one();
    check_val("wrap_0000",  evt_ts, 16'h0000);
    rst = 1'b1;
    tick();
    check_val("rst3_valid", evt_valid, 0);
    rst = 1'b0;
    tick(5);
    check_val("rst3_flushed", evt_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
